// File: rtl/three_way_traffic_pkg.sv
// Purpose : shared lamp codes, FSM state encoding and state-to-lamp decode for the junction controller.
// Latency : n/a (types and a pure function only).
// Backpressure: n/a.
package three_way_traffic_pkg;

   // One-hot lamp codes, bit order {R,Y,G}
   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   // Six fixed phases plus the optional all-red clearance; encoding 3'd7 is unused
   typedef enum logic [2:0] {
      ST_S1     = 3'd0,
      ST_S2     = 3'd1,
      ST_S3     = 3'd2,
      ST_S4     = 3'd3,
      ST_S5     = 3'd4,
      ST_S6     = 3'd5,
      ST_ALLRED = 3'd6
   } state_t;

   // Four signal heads packed for a single-expression decode
   typedef struct packed {
      logic [2:0] m1;
      logic [2:0] m2;
      logic [2:0] mt;
      logic [2:0] s;
   } lamps_t;

   // Map a state to the four heads; anything unexpected shows all red
   function automatic lamps_t state_lamps(input state_t st);
      lamps_t l;
      l = '{m1: RED, m2: RED, mt: RED, s: RED};
      case (st)
         ST_S1:   l = '{m1: GRN, m2: GRN, mt: RED, s: RED};
         ST_S2:   l = '{m1: GRN, m2: YEL, mt: RED, s: RED};
         ST_S3:   l = '{m1: GRN, m2: RED, mt: GRN, s: RED};
         ST_S4:   l = '{m1: YEL, m2: RED, mt: YEL, s: RED};
         ST_S5:   l = '{m1: RED, m2: RED, mt: RED, s: GRN};
         ST_S6:   l = '{m1: RED, m2: RED, mt: RED, s: YEL};
         default: l = '{m1: RED, m2: RED, mt: RED, s: RED};
      endcase
      return l;
   endfunction

endpackage

// File: rtl/three_way_traffic_ctrl_dwell_timer.sv
// Purpose : dwell counter for the current phase; flags the last cycle of the phase.
// Latency : o_done is combinational from the count; count updates every rising edge.
// Backpressure: none, free-running; i_clr forces the count back to zero.
module tlc_dwell_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_clr,
   input  logic [W-1:0] i_limit,
   output logic         o_done
);

   logic [W-1:0] r_cnt;

   // Last cycle of the phase when the count reaches limit-1 (limit is always >= 1)
   assign o_done = (r_cnt == (i_limit - W'(1)));

   // Count up, wrapping to zero at the end of a phase or on a forced clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_cnt <= '0;
      else if (i_clr || o_done)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + W'(1);
   end

endmodule

// File: rtl/three_way_traffic_ctrl.sv
// Purpose : fixed-time six-phase controller for a three-way junction (M1, M2, MT, S heads);
//           TLC_ALL_RED_EN inserts an all-red clearance after S4 and after S6.
// Latency : lamps decode the state register directly; each phase holds for its dwell in edges.
// Backpressure: none, no inputs besides clock and reset.
module three_way_traffic_ctrl
   import three_way_traffic_pkg::*;
#(
   parameter int T_MAIN   = 7,
   parameter int T_TURN   = 5,
   parameter int T_SIDE   = 3,
   parameter int T_YEL    = 2,
   parameter int T_ALLRED = 1
) (
   input  logic       clk,
   input  logic       reset,
   output logic [2:0] light_M1,
   output logic [2:0] light_M2,
   output logic [2:0] light_MT,
   output logic [2:0] light_S
);

   localparam int T_MAX0 = (T_MAIN > T_TURN) ? T_MAIN : T_TURN;
   localparam int T_MAX1 = (T_MAX0 > T_SIDE) ? T_MAX0 : T_SIDE;
   localparam int T_MAX2 = (T_MAX1 > T_YEL)  ? T_MAX1 : T_YEL;
   localparam int T_MAX  = (T_MAX2 > T_ALLRED) ? T_MAX2 : T_ALLRED;
   localparam int W      = $clog2(T_MAX + 1);

   state_t       r_state;
   logic         r_ar_to_side;   // all-red phase is followed by S5 (1) or S1 (0)
   logic [W-1:0] w_limit;
   logic         w_done;
   logic         w_clr;
   lamps_t       w_lamps;

   // Dwell length of the phase currently held in the state register
   always_comb begin
      w_limit = W'(1);
      case (r_state)
         ST_S1:     w_limit = W'(T_MAIN);
         ST_S2:     w_limit = W'(T_YEL);
         ST_S3:     w_limit = W'(T_TURN);
         ST_S4:     w_limit = W'(T_YEL);
         ST_S5:     w_limit = W'(T_SIDE);
         ST_S6:     w_limit = W'(T_YEL);
         ST_ALLRED: w_limit = W'(T_ALLRED);
         default:   w_limit = W'(1);
      endcase
   end

   // Flag encodings that should never be held so the FSM and timer restart cleanly
   always_comb begin
      w_clr = 1'b0;
      case (r_state)
         ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6: w_clr = 1'b0;
`ifdef TLC_ALL_RED_EN
         ST_ALLRED: w_clr = 1'b0;
`endif
         default:   w_clr = 1'b1;
      endcase
   end

   tlc_dwell_timer #(.W(W)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (w_clr),
      .i_limit (w_limit),
      .o_done  (w_done)
   );

   // Phase sequencer: advance when the dwell expires, recover to S1 from any stray encoding
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_S1;
         r_ar_to_side <= 1'b0;
      end else if (w_clr) begin
         r_state      <= ST_S1;
         r_ar_to_side <= 1'b0;
      end else if (w_done) begin
         case (r_state)
            ST_S1: r_state <= ST_S2;
            ST_S2: r_state <= ST_S3;
            ST_S3: r_state <= ST_S4;
`ifdef TLC_ALL_RED_EN
            ST_S4: begin
               r_state      <= ST_ALLRED;
               r_ar_to_side <= 1'b1;
            end
            ST_S5: r_state <= ST_S6;
            ST_S6: begin
               r_state      <= ST_ALLRED;
               r_ar_to_side <= 1'b0;
            end
            ST_ALLRED: r_state <= r_ar_to_side ? ST_S5 : ST_S1;
`else
            ST_S4: r_state <= ST_S5;
            ST_S5: r_state <= ST_S6;
            ST_S6: r_state <= ST_S1;
`endif
            default: r_state <= ST_S1;
         endcase
      end
   end

   // Moore decode straight from the state register
   assign w_lamps  = state_lamps(r_state);
   assign light_M1 = w_lamps.m1;
   assign light_M2 = w_lamps.m2;
   assign light_MT = w_lamps.mt;
   assign light_S  = w_lamps.s;

endmodule

// File: tb/tb_three_way_traffic_ctrl.sv
// Purpose : directed self-checking bench for three_way_traffic_ctrl (default and all-ones timing).
// Latency : lamps sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_three_way_traffic_ctrl;

   logic       clk;
   logic       reset;
   logic       reset_f;
   logic [2:0] m1, m2, mt, s;
   logic [2:0] m1_f, m2_f, mt_f, s_f;

   int checks = 0;
   int errors = 0;

   three_way_traffic_ctrl dut (
      .clk(clk), .reset(reset),
      .light_M1(m1), .light_M2(m2), .light_MT(mt), .light_S(s)
   );

   three_way_traffic_ctrl #(
      .T_MAIN(1), .T_TURN(1), .T_SIDE(1), .T_YEL(1), .T_ALLRED(1)
   ) dut_f (
      .clk(clk), .reset(reset_f),
      .light_M1(m1_f), .light_M2(m2_f), .light_MT(mt_f), .light_S(s_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef TLC_ALL_RED_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   // Expected {M1,M2,MT,S}; phase 0..5 = S1..S6, 6 = all red
   function automatic logic [11:0] lamps_of(input int ph);
      case (ph)
         0:       return 12'b001_001_100_100;
         1:       return 12'b001_010_100_100;
         2:       return 12'b001_100_001_100;
         3:       return 12'b010_100_010_100;
         4:       return 12'b100_100_100_001;
         5:       return 12'b100_100_100_010;
         default: return 12'b100_100_100_100;
      endcase
   endfunction

   // Phase held after k rising edges since reset release
   function automatic int phase_at(input int k, input int tm, input int tt,
                                   input int ts, input int ty, input int ta);
      int ph[8];
      int d[8];
      int n, p, r;
      n = 0;
      ph[n] = 0; d[n] = tm; n++;
      ph[n] = 1; d[n] = ty; n++;
      ph[n] = 2; d[n] = tt; n++;
      ph[n] = 3; d[n] = ty; n++;
      if (AR) begin ph[n] = 6; d[n] = ta; n++; end
      ph[n] = 4; d[n] = ts; n++;
      ph[n] = 5; d[n] = ty; n++;
      if (AR) begin ph[n] = 6; d[n] = ta; n++; end
      p = 0;
      for (int i = 0; i < n; i++) p += d[i];
      r = k % p;
      for (int i = 0; i < n; i++) begin
         if (r < d[i]) return ph[i];
         r -= d[i];
      end
      return -1;
   endfunction

   function automatic int exp_def(input int k);
      return phase_at(k, 7, 5, 3, 2, 1);
   endfunction

   function automatic int exp_fast(input int k);
      return phase_at(k, 1, 1, 1, 1, 1);
   endfunction

   int period_def;
   int period_fast;

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({m1, m2, mt, s} !== lamps_of(0)) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, {m1, m2, mt, s}, lamps_of(0));
         end
      end
   endtask

   task automatic test_default_cycle();
      @(negedge clk); reset = 1'b1;
      checks++;
      if ({m1, m2, mt, s} !== lamps_of(0)) begin
         errors++;
         $display("FAIL cycle_start got=%b exp=%b", {m1, m2, mt, s}, lamps_of(0));
      end
      for (int j = 1; j <= 9 * period_def; j++) begin
         @(posedge clk); #1;
         checks++;
         if ({m1, m2, mt, s} !== lamps_of(exp_def(j))) begin
            errors++;
            $display("FAIL default_cycle edge=%0d got=%b exp=%b", j, {m1, m2, mt, s},
                     lamps_of(exp_def(j)));
         end
      end
   endtask

   task automatic test_async_reset();
      // Fresh start, then walk into S5
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;
      for (int j = 1; j <= 17; j++) begin
         @(posedge clk); #1;
      end
      checks++;
      if ({m1, m2, mt, s} !== lamps_of(4)) begin
         errors++;
         $display("FAIL async_in_s5 got=%b exp=%b", {m1, m2, mt, s}, lamps_of(4));
      end
      // Assert reset between edges; outputs must snap back without a clock edge
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({m1, m2, mt, s} !== lamps_of(0)) begin
         errors++;
         $display("FAIL async_immediate got=%b exp=%b", {m1, m2, mt, s}, lamps_of(0));
      end
      @(negedge clk); reset = 1'b1;
      for (int j = 1; j <= 7; j++) begin
         @(posedge clk); #1;
         checks++;
         if ({m1, m2, mt, s} !== lamps_of(exp_def(j))) begin
            errors++;
            $display("FAIL async_release edge=%0d got=%b exp=%b", j, {m1, m2, mt, s},
                     lamps_of(exp_def(j)));
         end
      end
   endtask

   task automatic test_invariant();
      logic bad;
      for (int j = 8; j < 208; j++) begin
         @(posedge clk); #1;
         bad = 1'b0;
         if (!$onehot(m1) || !$onehot(m2) || !$onehot(mt) || !$onehot(s)) bad = 1'b1;
         if ((s == 3'b001 || s == 3'b010) &&
             (m1 != 3'b100 || m2 != 3'b100 || mt != 3'b100)) bad = 1'b1;
         if (mt != 3'b100 && m2 != 3'b100) bad = 1'b1;
         checks++;
         if (bad) begin
            errors++;
            $display("FAIL invariant edge=%0d got=%b exp=safe", j, {m1, m2, mt, s});
         end
         checks++;
         if ({m1, m2, mt, s} !== lamps_of(exp_def(j))) begin
            errors++;
            $display("FAIL long_run edge=%0d got=%b exp=%b", j, {m1, m2, mt, s},
                     lamps_of(exp_def(j)));
         end
      end
   endtask

   task automatic test_fast_params();
      @(negedge clk); reset_f = 1'b1;
      checks++;
      if ({m1_f, m2_f, mt_f, s_f} !== lamps_of(0)) begin
         errors++;
         $display("FAIL fast_start got=%b exp=%b", {m1_f, m2_f, mt_f, s_f}, lamps_of(0));
      end
      for (int j = 1; j <= 3 * period_fast; j++) begin
         @(posedge clk); #1;
         checks++;
         if ({m1_f, m2_f, mt_f, s_f} !== lamps_of(exp_fast(j))) begin
            errors++;
            $display("FAIL fast_cycle edge=%0d got=%b exp=%b", j, {m1_f, m2_f, mt_f, s_f},
                     lamps_of(exp_fast(j)));
         end
      end
   endtask

   initial begin
      reset       = 1'b0;
      reset_f     = 1'b0;
      period_def  = AR ? 23 : 21;
      period_fast = AR ? 8 : 6;
      test_reset();
      test_default_cycle();
      test_async_reset();
      test_invariant();
      test_fast_params();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/three_way_traffic_ctrl.md
Name: three_way_traffic_ctrl

Overview:
- Fixed-time controller for a three-way junction with four signal heads: main road direction 1 (M1), main road direction 2 (M2), main-road turn lane (MT) and side road (S).
- Moore FSM with a dwell counter that steps through a six-phase cycle; every phase lasts a parameterised number of clock cycles.
- Standalone top-level block driving the lamp drivers directly. No inputs besides clock and reset.

Parameters:
- T_MAIN, 7, cycles in S1 (M1+M2 green)
- T_TURN, 5, cycles in S3 (M1+MT green)
- T_SIDE, 3, cycles in S5 (S green)
- T_YEL, 2, cycles in every yellow phase (S2, S4, S6)
- T_ALLRED, 1, cycles of all-red clearance (used only with the optional feature)
- Legality: all values >= 1. Counter width = $clog2(max parameter + 1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- light_M1  output  3  M1 lamp {R,Y,G}
- light_M2  output  3  M2 lamp {R,Y,G}
- light_MT  output  3  MT lamp {R,Y,G}
- light_S  output  3  S lamp {R,Y,G}

Behaviour:
- Lamp encoding is one-hot: RED=3'b100, YEL=3'b010, GRN=3'b001. No other value is ever driven.
- Outputs are a pure combinational decode of the state register (Moore); there are no output glitches between states.
- Phase table, listed as state: M1/M2/MT/S, dwell:
  - S1: GRN/GRN/RED/RED, T_MAIN
  - S2: GRN/YEL/RED/RED, T_YEL
  - S3: GRN/RED/GRN/RED, T_TURN
  - S4: YEL/RED/YEL/RED, T_YEL
  - S5: RED/RED/RED/GRN, T_SIDE
  - S6: RED/RED/RED/YEL, T_YEL
  - Then back to S1.
- Reset (reset=0, asynchronous): state=S1, counter=0.
  - Outputs during reset: M1=GRN, M2=GRN, MT=RED, S=RED.
  - Reset asserted mid-phase aborts the phase immediately, with no waiting for a clock edge.
- Dwell counting:
  - On each rising edge, if counter == T_cur-1 the state advances and the counter clears to 0; otherwise the counter increments.
  - Each state therefore holds for exactly T_cur rising edges after entry, counting from the first edge after reset deassertion.
- Full cycle = T_MAIN + T_TURN + T_SIDE + 3*T_YEL = 21 cycles at defaults.
- Safety invariant: S is never GRN or YEL while any of M1, M2 or MT is non-RED. MT and M2 are never both non-RED.
- Unreachable state encodings recover to S1 with counter 0 on the next edge.

Optional Feature:
- Macro: TLC_ALL_RED_EN.
- Defined: an all-red state (every head RED) lasting T_ALLRED cycles is inserted between S4→S5 and between S6→S1. Full cycle = 21 + 2*T_ALLRED (23 at defaults).
- Undefined: no all-red states, the T_ALLRED parameter is ignored, and the cycle is exactly as in the phase table.

Decomposition:
- Package three_way_traffic_pkg holds:
  - lamp localparams RED/YEL/GRN
  - state typedef/encoding for S1..S6 plus ALLRED
  - a function mapping state to the four lamp vectors
- Natural sub-module: tlc_dwell_timer (loadable down/up counter with a "done" flag). The FSM and output decode remain in the top module.

Test Plan:
- Reset hold: reset=0 for 3 cycles → M1=001, M2=001, MT=100, S=100, with no state change.
- Default cycle: release reset, count edges → S1 for 7, S2 for 2, S3 for 5, S4 for 2, S5 for 3, S6 for 2; back to S1 at edge 21, then repeats for at least 9 cycles.
- Async mid-phase reset: assert reset=0 between clock edges during S5 → outputs return to S1 values immediately. After release, S1 lasts the full 7 edges.
- Invariant monitor across 200 cycles: S ∈ {GRN,YEL} implies M1=M2=MT=100; MT≠100 implies M2=100; every lamp is one-hot.
- Parameter override (T_MAIN=1, T_YEL=1, T_TURN=1, T_SIDE=1) → each state lasts 1 edge; period = 6.
- With TLC_ALL_RED_EN: all four heads read 100 for 1 cycle after S4 and after S6; period = 23.
